// File: rtl/mu_particle_cache_ctrl.sv
// mu_particle_cache_ctrl
// Write-back end of the motion-update ring for one cell. Two particle banks
// are used ping-pong style: the ACTIVE bank (o_bank_sel) serves MU reads for
// the current step while the SHADOW bank collects returned packets at an
// internal write counter. Once the MU has issued its last particle and the
// ring has stayed idle for DRAIN_CYCLES consecutive cycles, the banks swap.
//
// Optional feature: define MU_CACHE_RD_REG_EN to add an output register on
// the read path (read latency 2 instead of 1).
//
// Handshakes: there is no backpressure anywhere. i_rd_en issues one read per
// cycle and o_rd_valid answers it a fixed number of cycles later; i_wb_valid
// presents one packet per cycle that is either stored or dropped in that
// same cycle.

module mu_particle_cache_ctrl #(
  parameter int ADDR_WIDTH   = 7,
  parameter int OFF_W        = 48,
  parameter int VEL_W        = 96,
  parameter int ELEM_W       = 2,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_init_wr,
  input  logic [ADDR_WIDTH-1:0]           i_init_addr,
  input  logic [OFF_W+VEL_W+ELEM_W-1:0]   i_init_data,
  input  logic [ADDR_WIDTH:0]             i_init_num,
  input  logic                            i_init_done,
  input  logic                            i_MU_start,
  input  logic                            i_rd_en,
  input  logic [ADDR_WIDTH-1:0]           i_rd_addr,
  output logic [OFF_W+VEL_W+ELEM_W-1:0]   o_rd_data,
  output logic                            o_rd_valid,
  input  logic                            i_wb_valid,
  input  logic [OFF_W-1:0]                i_wb_offset,
  input  logic [VEL_W-1:0]                i_wb_vel,
  input  logic [ELEM_W-1:0]               i_wb_element,
  input  logic                            i_MU_done,
  input  logic                            i_ring_idle,
  output logic [ADDR_WIDTH:0]             o_particle_num,
  output logic                            o_busy,
  output logic                            o_swap_done,
  output logic                            o_overflow,
  output logic                            o_bank_sel,
  output logic [1:0]                      o_dbg_state
);

  localparam int DW    = OFF_W + VEL_W + ELEM_W;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [7:0]    DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SWAP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Both banks live in one array; the top address bit selects the bank.
  logic [DW-1:0] mem [0:2*DEPTH-1];

  logic [CW-1:0]     wr_cnt;
  logic [7:0]        idle_cnt;
  logic              ring_quiet;
  logic              wb_accept;
  logic              wb_full;
  logic              wb_store;
  logic              mem_we;
  logic [ADDR_WIDTH:0] mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic              rd_valid_s1;
  logic [DW-1:0]     rd_data_s1;

  assign ring_quiet = i_ring_idle & ~i_wb_valid;
  assign wb_accept  = i_wb_valid & (state != ST_IDLE);
  assign wb_full    = (wr_cnt == CNT_FULL);
  assign wb_store   = wb_accept & ~wb_full;

  assign o_busy      = (state == ST_UPDATE) || (state == ST_DRAIN);
  assign o_dbg_state = state;

  // Next-state logic: start from IDLE, done from UPDATE, swap after a
  // sustained quiet ring, then straight back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_MU_start) state_nxt = ST_UPDATE;
      ST_UPDATE: if (i_MU_done)  state_nxt = ST_DRAIN;
      ST_DRAIN:  if (ring_quiet && (idle_cnt == DRAIN_LAST)) state_nxt = ST_SWAP;
      ST_SWAP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Single RAM write port: write-backs go to SHADOW outside IDLE, initial
  // loads go to ACTIVE inside IDLE, so the two never collide.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (wb_store) begin
      mem_we    = 1'b1;
      mem_waddr = {~o_bank_sel, wr_cnt[ADDR_WIDTH-1:0]};
      mem_wdata = {i_wb_element, i_wb_vel, i_wb_offset};
    end else if ((state == ST_IDLE) && i_init_wr) begin
      mem_we    = 1'b1;
      mem_waddr = {o_bank_sel, i_init_addr};
      mem_wdata = i_init_data;
    end
  end

  // Control registers: state, write counter, drain timer, bank select, count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      o_bank_sel     <= 1'b0;
      o_particle_num <= '0;
      wr_cnt         <= '0;
      idle_cnt       <= '0;
      o_swap_done    <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_swap_done <= (state == ST_SWAP);
      idle_cnt    <= ((state == ST_DRAIN) && ring_quiet) ? idle_cnt + 8'd1 : 8'd0;
      if (state == ST_IDLE) begin
        if (i_MU_start) begin
          wr_cnt     <= '0;
          o_overflow <= 1'b0;
        end
        if (i_init_done) o_particle_num <= i_init_num;
      end else if (wb_accept) begin
        if (wb_full) o_overflow <= 1'b1;
        else         wr_cnt     <= wr_cnt + CW'(1);
      end
      // The count published at swap includes a packet stored in the SWAP cycle.
      if (state == ST_SWAP) begin
        o_bank_sel     <= ~o_bank_sel;
        o_particle_num <= wr_cnt + CW'(wb_store);
      end
    end
  end

  // Bank RAM write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // First read stage: ACTIVE bank lookup, valid follows the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_s1 <= 1'b0;
      rd_data_s1  <= '0;
    end else begin
      rd_valid_s1 <= i_rd_en;
      if (i_rd_en) rd_data_s1 <= mem[{o_bank_sel, i_rd_addr}];
    end
  end

`ifdef MU_CACHE_RD_REG_EN
  logic          rd_valid_s2;
  logic [DW-1:0] rd_data_s2;

  // Extra output register for timing closure on the read path.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_s2 <= 1'b0;
      rd_data_s2  <= '0;
    end else begin
      rd_valid_s2 <= rd_valid_s1;
      rd_data_s2  <= rd_data_s1;
    end
  end

  assign o_rd_valid = rd_valid_s2;
  assign o_rd_data  = rd_data_s2;
`else
  assign o_rd_valid = rd_valid_s1;
  assign o_rd_data  = rd_data_s1;
`endif

endmodule

// File: tb/tb_mu_particle_cache_ctrl.sv
// Testbench for mu_particle_cache_ctrl (small instance: 8 entries per bank).
// Reference model: two bank arrays plus a queue of accepted write-backs; at
// a swap the queue (clipped to the bank depth) becomes the new ACTIVE bank.

module tb_mu_particle_cache_ctrl;

  localparam int AW    = 3;
  localparam int OW    = 8;
  localparam int VW    = 8;
  localparam int EW    = 4;
  localparam int DC    = 8;
  localparam int DW    = OW + VW + EW;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;
`ifdef MU_CACHE_RD_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic          i_init_wr;
  logic [AW-1:0] i_init_addr;
  logic [DW-1:0] i_init_data;
  logic [CW-1:0] i_init_num;
  logic          i_init_done;
  logic          i_MU_start;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          i_wb_valid;
  logic [OW-1:0] i_wb_offset;
  logic [VW-1:0] i_wb_vel;
  logic [EW-1:0] i_wb_element;
  logic          i_MU_done;
  logic          i_ring_idle;
  logic [CW-1:0] o_particle_num;
  logic          o_busy;
  logic          o_swap_done;
  logic          o_overflow;
  logic          o_bank_sel;
  logic [1:0]    o_dbg_state;

  mu_particle_cache_ctrl #(
    .ADDR_WIDTH(AW), .OFF_W(OW), .VEL_W(VW), .ELEM_W(EW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst),
    .i_init_wr(i_init_wr), .i_init_addr(i_init_addr), .i_init_data(i_init_data),
    .i_init_num(i_init_num), .i_init_done(i_init_done),
    .i_MU_start(i_MU_start),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .i_wb_valid(i_wb_valid), .i_wb_offset(i_wb_offset), .i_wb_vel(i_wb_vel),
    .i_wb_element(i_wb_element),
    .i_MU_done(i_MU_done), .i_ring_idle(i_ring_idle),
    .o_particle_num(o_particle_num), .o_busy(o_busy), .o_swap_done(o_swap_done),
    .o_overflow(o_overflow), .o_bank_sel(o_bank_sel), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mb [2][DEPTH];
  logic [DW-1:0] pkt_q[$];
  bit            msel;
  int            mnum;
  bit            movf;
  bit            mbusy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read monitor: every valid must answer an outstanding request, in order.
  always @(negedge clk) begin
    if (o_rd_valid) begin
      check("rd_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("rd_data", o_rd_data, exp_q.pop_front());
    end
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic rd(input int a);
    i_rd_en   = 1'b1;
    i_rd_addr = AW'(a);
    exp_q.push_back(mb[msel][a]);
    @(negedge clk);
    i_rd_en   = 1'b0;
  endtask

  task automatic flush();
    repeat (LAT + 1) @(negedge clk);
    check("rd_q_empty", exp_q.size(), 0);
  endtask

  task automatic measure_lat(input int a);
    int k;
    i_rd_en   = 1'b1;
    i_rd_addr = AW'(a);
    exp_q.push_back(mb[msel][a]);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      i_rd_en = 1'b0;
    end while (!o_rd_valid && k < 6);
    check("rd_latency", k, LAT);
  endtask

  task automatic init_load(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d           = DW'($urandom);
      i_init_wr   = 1'b1;
      i_init_addr = AW'(i);
      i_init_data = d;
      mb[msel][i] = d;
      @(negedge clk);
    end
    i_init_wr   = 1'b0;
    i_init_num  = CW'(n);
    i_init_done = 1'b1;
    @(negedge clk);
    i_init_done = 1'b0;
    mnum        = n;
  endtask

  task automatic send_wb();
    logic [DW-1:0] p;
    p            = DW'($urandom);
    i_wb_offset  = p[OW-1:0];
    i_wb_vel     = p[OW+VW-1:OW];
    i_wb_element = p[DW-1:OW+VW];
    i_wb_valid   = 1'b1;
    if (mbusy) pkt_q.push_back(p);
    @(negedge clk);
    i_wb_valid   = 1'b0;
  endtask

  task automatic mu_start();
    i_MU_start = 1'b1;
    @(negedge clk);
    i_MU_start = 1'b0;
    mbusy      = 1'b1;
    movf       = 1'b0;
    pkt_q.delete();
  endtask

  task automatic mu_done();
    i_MU_done = 1'b1;
    @(negedge clk);
    i_MU_done = 1'b0;
  endtask

  task automatic model_swap();
    int n;
    n = (pkt_q.size() > DEPTH) ? DEPTH : pkt_q.size();
    for (int i = 0; i < n; i++) mb[~msel][i] = pkt_q[i];
    movf  = (pkt_q.size() > DEPTH);
    mnum  = n;
    msel  = ~msel;
    mbusy = 1'b0;
    pkt_q.delete();
  endtask

  // Hold the ring idle and expect the swap pulse DC+1 edges later; optionally
  // issue a read during the SWAP cycle (must see the old ACTIVE bank).
  task automatic wait_swap(input bit swap_rd, input int ra);
    int k;
    bit seen;
    seen        = 1'b0;
    i_ring_idle = 1'b1;
    for (k = 1; k <= DC + 6; k++) begin
      @(negedge clk);
      i_rd_en = 1'b0;
      if (o_swap_done) begin
        seen = 1'b1;
        break;
      end
      if (swap_rd && k == DC) begin
        i_rd_en   = 1'b1;
        i_rd_addr = AW'(ra);
        exp_q.push_back(mb[msel][ra]);
      end
    end
    i_rd_en     = 1'b0;
    i_ring_idle = 1'b0;
    check("swap_seen", seen, 1);
    check("swap_cycles", k, DC + 1);
    @(negedge clk);
    check("swap_pulse_len", o_swap_done, 0);
    model_swap();
    check("swap_bank_sel", o_bank_sel, msel);
    check("swap_num", o_particle_num, mnum);
    check("swap_busy", o_busy, 0);
    check("swap_ovf", o_overflow, movf);
  endtask

  // Directed sequence
  initial begin
    int sw;
    rst = 1'b1; i_init_wr = 0; i_init_addr = 0; i_init_data = 0; i_init_num = 0;
    i_init_done = 0; i_MU_start = 0; i_rd_en = 0; i_rd_addr = 0; i_wb_valid = 0;
    i_wb_offset = 0; i_wb_vel = 0; i_wb_element = 0; i_MU_done = 0; i_ring_idle = 0;
    msel = 0; mnum = 0; movf = 0; mbusy = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) mb[b][i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_bank_sel", o_bank_sel, 0);
    check("rst_num", o_particle_num, 0);
    check("rst_busy", o_busy, 0);
    check("rst_swap_done", o_swap_done, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_rd_data", o_rd_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Initial load of 5 entries, read them back
    init_load(5);
    check("init_num", o_particle_num, 5);
    measure_lat(0);
    for (int a = 1; a < 5; a++) rd(a);
    flush();

    // Normal update step
    mu_start();
    check("upd_busy", o_busy, 1);
    for (int i = 0; i < 5; i++) send_wb();
    mu_done();
    wait_swap(1'b0, 0);
    for (int a = 0; a < 5; a++) rd(a);
    flush();

    // Ignored controls
    send_wb();
    send_wb();
    check("idle_wb_ovf", o_overflow, 0);
    check("idle_wb_num", o_particle_num, mnum);
    i_MU_start = 1'b1; i_MU_done = 1'b1; i_ring_idle = 1'b1;
    @(negedge clk);
    i_MU_start = 1'b0; i_MU_done = 1'b0;
    mbusy = 1'b1; movf = 1'b0; pkt_q.delete();
    sw = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_swap_done) sw++;
    end
    i_ring_idle = 1'b0;
    check("start_done_no_swap", sw, 0);
    check("start_done_busy", o_busy, 1);
    i_init_wr = 1'b1; i_init_addr = '0; i_init_data = ~mb[msel][0];
    i_init_num = CW'(7); i_init_done = 1'b1;
    @(negedge clk);
    i_init_wr = 1'b0; i_init_done = 1'b0;
    check("upd_init_num", o_particle_num, mnum);
    rd(0);
    flush();
    send_wb();
    i_MU_start = 1'b1;
    @(negedge clk);
    i_MU_start = 1'b0;
    send_wb();
    mu_done();
    wait_swap(1'b1, 1);
    for (int a = 0; a < 2; a++) rd(a);
    flush();

    // Drain interrupted by a late packet
    mu_start();
    for (int i = 0; i < 5; i++) send_wb();
    mu_done();
    i_ring_idle = 1'b1;
    repeat (5) @(negedge clk);
    check("drain_no_early_swap", o_bank_sel, msel);
    check("drain_busy", o_busy, 1);
    i_ring_idle = 1'b0;
    send_wb();
    wait_swap(1'b0, 0);
    for (int a = 0; a < 6; a++) rd(a);
    flush();

    // Overflow: 9 packets into an 8-entry bank
    mu_start();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("ovf_before", o_overflow, 0);
      send_wb();
    end
    check("ovf_after", o_overflow, 1);
    mu_done();
    wait_swap(1'b0, 0);
    for (int a = 0; a < DEPTH; a++) rd(a);
    flush();

    // Reset in DRAIN with a read issued in the reset cycle
    mu_start();
    check("ovf_cleared", o_overflow, 0);
    send_wb();
    send_wb();
    mu_done();
    i_ring_idle = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; i_rd_en = 1'b1; i_rd_addr = '0;
    @(negedge clk);
    rst = 1'b0; i_rd_en = 1'b0; i_ring_idle = 1'b0;
    msel = 1'b0; mnum = 0; mbusy = 1'b0; pkt_q.delete();
    check("mid_rst_bank_sel", o_bank_sel, 0);
    check("mid_rst_num", o_particle_num, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_rd_valid", o_rd_valid, 0);
    @(negedge clk);
    check("mid_rst_rd_valid2", o_rd_valid, 0);
    check("mid_rst_swap", o_swap_done, 0);
    init_load(3);
    check("post_rst_num", o_particle_num, 3);
    measure_lat(0);
    rd(1);
    rd(2);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mu_particle_cache_ctrl.md
Name: mu_particle_cache_ctrl

Overview:
- Write-back end of the motion-update (MU) ring: accepts updated/migrated particle packets returned to this cell, feeds the MU its per-particle read data.
- Holds two particle banks (ping-pong): ACTIVE bank serves MU reads for the current step, SHADOW bank collects write-backs via an internal address counter; banks swap once the ring drains.
- One instance per cell, between the MU controller (reads/returns) and the force-evaluation position cache loader.

Parameters:
- ADDR_WIDTH, default PARTICLE_ID_WIDTH, bank address width; DEPTH = 2**ADDR_WIDTH entries per bank.
- OFF_W, default OFFSET_STRUCT_WIDTH, offset field width.
- VEL_W, default FLOAT_STRUCT_WIDTH, velocity field width.
- ELEM_W, default ELEMENT_WIDTH, element field width.
- DRAIN_CYCLES, default 8, consecutive ring-idle cycles required before swap (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_init_wr  in  1  initial-load write strobe into ACTIVE bank (IDLE only)
- i_init_addr  in  ADDR_WIDTH  initial-load address
- i_init_data  in  OFF_W+VEL_W+ELEM_W  initial-load entry {element,vel,offset}
- i_init_num  in  ADDR_WIDTH+1  particle count latched with i_init_done
- i_init_done  in  1  pulse: latch i_init_num as ACTIVE particle count
- i_MU_start  in  1  pulse: begin update step
- i_rd_en  in  1  MU read request
- i_rd_addr  in  ADDR_WIDTH  MU read address
- o_rd_data  out  OFF_W+VEL_W+ELEM_W  ACTIVE-bank entry {element,vel,offset}
- o_rd_valid  out  1  o_rd_data valid
- i_wb_valid  in  1  returned packet valid (MU o_data_valid)
- i_wb_offset  in  OFF_W  returned offset
- i_wb_vel  in  VEL_W  returned velocity
- i_wb_element  in  ELEM_W  returned element
- i_MU_done  in  1  pulse: local MU issued last particle
- i_ring_idle  in  1  high when all MU buffers empty and no fwd valid on ring
- o_particle_num  out  ADDR_WIDTH+1  ACTIVE particle count
- o_busy  out  1  high in UPDATE or DRAIN
- o_swap_done  out  1  one-cycle pulse on bank swap
- o_overflow  out  1  sticky: write-back dropped because SHADOW full
- o_bank_sel  out  1  index of ACTIVE bank

Behaviour:
- Reset: state IDLE; o_bank_sel=0; o_particle_num=0; wr_cnt=0; idle_cnt=0; o_rd_valid=0; o_rd_data=0; o_busy=0; o_swap_done=0; o_overflow=0. Bank RAM contents not reset.
- FSM IDLE -> UPDATE on i_MU_start (wr_cnt<=0, o_overflow<=0). UPDATE -> DRAIN on i_MU_done. DRAIN -> SWAP when idle_cnt reaches DRAIN_CYCLES (idle_cnt increments while i_ring_idle & ~i_wb_valid, clears otherwise). SWAP -> IDLE next cycle: o_bank_sel toggles, o_particle_num<=wr_cnt (value incl. any write in SWAP cycle), o_swap_done pulses in IDLE-entry cycle.
- i_MU_start outside IDLE ignored. i_MU_done outside UPDATE ignored. i_MU_start and i_MU_done same cycle in IDLE: start wins, done ignored.
- Write-back: accepted in UPDATE, DRAIN and SWAP; writes SHADOW[wr_cnt], wr_cnt++. wr_cnt==DEPTH: packet dropped, o_overflow<=1, wr_cnt holds. i_wb_valid in IDLE: dropped, no flag.
- Reads: i_rd_en -> o_rd_data = ACTIVE[i_rd_addr], o_rd_valid=1 exactly 1 cycle later; one read/cycle, no backpressure. Reads allowed in any state; address >= o_particle_num returns RAM content (MU must bound reads by o_particle_num). Read and write-back same cycle never conflict (different banks).
- Read issued in SWAP cycle returns old ACTIVE bank data.
- Init load: i_init_wr honoured only in IDLE, writes ACTIVE bank; i_init_done in IDLE latches o_particle_num<=i_init_num; both ignored otherwise.
- Reset mid-operation: return to IDLE, bank 0 ACTIVE, in-flight read valid dropped.

Optional Feature:
- Macro MU_CACHE_RD_REG_EN. Defined: extra output register on read path; o_rd_data/o_rd_valid latency 2 cycles, pipeline cleared by rst. Undefined: latency 1 as above.

Test Plan:
- Reset then init load 5 entries, i_init_num=5, reads addr 0..4 -> o_rd_valid 1 cycle later, data match, o_particle_num=5.
- i_MU_start, 5 write-backs, i_MU_done, i_ring_idle high 8 cycles -> SWAP, o_swap_done one pulse, o_bank_sel=1, o_particle_num=5, reads return written packets in arrival order.
- DRAIN with i_ring_idle dropping at idle cycle 5 plus late write-back -> no swap until 8 fresh idle cycles; late packet stored, o_particle_num=6.
- ADDR_WIDTH=3: 9 write-backs in UPDATE -> first 8 stored, o_overflow=1, o_particle_num=8 after swap.
- i_MU_start during UPDATE and i_wb_valid in IDLE -> ignored; wr_cnt, counts unchanged.
- rst asserted in DRAIN -> next cycle IDLE, o_bank_sel=0, o_particle_num=0, o_busy=0; with MU_CACHE_RD_REG_EN read latency measured 2.
